sram_bridge32: RTL and testbench

- Bridges the 32-bit CPU data bus to the 16-bit asynchronous-handshake SRAM port.
- Sits directly upstream of the SRAM controller/model.
- Splits each word access into low then high half-word SRAM accesses.
- Performs read-modify-write for partial half-word byte masks and skips halves whose mask is all-zero.

---
 rtl/sram_bridge32_pkg.sv | 77 +++++++
 rtl/sram_bridge32_half_sequencer.sv | 63 ++++++
 rtl/sram_bridge32.sv | 163 ++++++++++++++++
 tb/tb_sram_bridge32.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge32_pkg.sv
// Shared types and helpers for the 32-bit CPU to 16-bit SRAM bridge.
package sram_bridge32_pkg;

  localparam int unsigned SRAM_ADDR_WIDTH_DEFAULT = 18;
  localparam int unsigned HALF_WIDTH              = 16;

  localparam logic LO = 1'b0;
  localparam logic HI = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LO_RD,
    ST_LO_WR,
    ST_LO_REL,
    ST_HI_RD,
    ST_HI_WR,
    ST_HI_REL,
    ST_DONE
  } state_e;

  // Position inside one half-word sequence; PH_NONE means the half is finished or skipped.
  typedef enum logic [1:0] {
    PH_NONE,
    PH_RD,
    PH_WR,
    PH_REL
  } phase_e;

  // Expand a 2-bit byte mask into a 16-bit bit mask for merging.
  function automatic logic [HALF_WIDTH-1:0] merge_mask(input logic [1:0] half_mask);
    return {{8{half_mask[1]}}, {8{half_mask[0]}}};
  endfunction

  // First access of a half: reads always read, full writes write, empty writes skip, partial writes read first.
  function automatic phase_e start_phase(input logic [1:0] half_mask, input logic rw);
    phase_e ph;
    ph = PH_RD;
    if (rw) begin
      if (half_mask == 2'b11) begin
        ph = PH_WR;
      end else if (half_mask == 2'b00) begin
        ph = PH_NONE;
      end
    end
    return ph;
  endfunction

  // Phase encoded by a bridge state.
  function automatic phase_e state_phase(input state_e st);
    phase_e ph;
    case (st)
      ST_LO_RD, ST_HI_RD:   ph = PH_RD;
      ST_LO_WR, ST_HI_WR:   ph = PH_WR;
      ST_LO_REL, ST_HI_REL: ph = PH_REL;
      default:              ph = PH_NONE;
    endcase
    return ph;
  endfunction

  // Half selected by a bridge state; idle and done report LO.
  function automatic logic state_half(input state_e st);
    return (st == ST_HI_RD || st == ST_HI_WR || st == ST_HI_REL) ? HI : LO;
  endfunction

  // Bridge state for a given half and phase.
  function automatic state_e half_state(input logic half, input phase_e ph);
    state_e st;
    case (ph)
      PH_RD:   st = (half == HI) ? ST_HI_RD  : ST_LO_RD;
      PH_WR:   st = (half == HI) ? ST_HI_WR  : ST_LO_WR;
      PH_REL:  st = (half == HI) ? ST_HI_REL : ST_LO_REL;
      default: st = ST_IDLE;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/sram_bridge32_half_sequencer.sv
// Runs one half-word RD / WR / REL sequence and holds the last half-word read.
module sram_bridge32_half_sequencer
  import sram_bridge32_pkg::*;
(
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  phase_e                i_phase,
  input  logic                  i_rw,
  input  logic [1:0]            i_half_mask,
  input  logic [HALF_WIDTH-1:0] i_wdata,
  input  logic                  i_sram_ready,
  input  logic [HALF_WIDTH-1:0] i_sram_rdata,
  output phase_e                o_next_phase_c,
  output logic                  o_done_c,
  output logic [HALF_WIDTH-1:0] o_rdata,
  output logic [HALF_WIDTH-1:0] o_merged_wdata_c
);

  logic                  wr_done_q;
  logic [HALF_WIDTH-1:0] byte_bits;

  // Capture read data on a completed read; remember whether this half's write has happened.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rdata   <= '0;
      wr_done_q <= 1'b0;
    end else if (i_phase == PH_RD && i_sram_ready) begin
      o_rdata   <= i_sram_rdata;
      wr_done_q <= 1'b0;
    end else if (i_phase == PH_WR && i_sram_ready) begin
      wr_done_q <= 1'b1;
    end
  end

  // Next phase: accesses wait for ready, release waits for ready to fall before continuing.
  always_comb begin
    o_next_phase_c = i_phase;
    o_done_c       = 1'b0;
    case (i_phase)
      PH_RD, PH_WR: begin
        if (i_sram_ready) o_next_phase_c = PH_REL;
      end
      PH_REL: begin
        if (!i_sram_ready) begin
          if (i_rw && !wr_done_q) begin
            o_next_phase_c = PH_WR;
          end else begin
            o_next_phase_c = PH_NONE;
            o_done_c       = 1'b1;
          end
        end
      end
      default: o_next_phase_c = PH_NONE;
    endcase
  end

  // Masked bytes come from the CPU, the rest from the preceding read.
  always_comb begin
    byte_bits        = merge_mask(i_half_mask);
    o_merged_wdata_c = (i_wdata & byte_bits) | (o_rdata & ~byte_bits);
  end

endmodule

// File: rtl/sram_bridge32.sv
// 32-bit CPU bus to 16-bit handshake SRAM bridge: low half then high half, RMW for partial masks.
module sram_bridge32
  import sram_bridge32_pkg::*;
#(
  parameter int unsigned SRAM_ADDR_WIDTH = SRAM_ADDR_WIDTH_DEFAULT
) (
  input  logic                       i_clock,
  input  logic                       i_reset_n,
  input  logic                       i_request,
  input  logic                       i_rw,
  input  logic [31:0]                i_address,
  input  logic [31:0]                i_wdata,
  input  logic [3:0]                 i_wmask,
  output logic [31:0]                o_rdata,
  output logic                       o_ready,
  output logic                       o_sram_enable,
  output logic                       o_sram_rw,
  output logic [SRAM_ADDR_WIDTH-1:0] o_sram_address,
  output logic [HALF_WIDTH-1:0]      o_sram_wdata,
  input  logic [HALF_WIDTH-1:0]      i_sram_rdata,
  input  logic                       i_sram_ready
);

  localparam int unsigned WORD_WIDTH = SRAM_ADDR_WIDTH - 1;

  state_e                 state_q, state_d;
  logic [WORD_WIDTH-1:0]  word_q, eff_word;
  logic [31:0]            wdata_q, eff_wdata;
  logic [3:0]             mask_q, eff_mask;
  logic                   rw_q, eff_rw;
  logic [HALF_WIDTH-1:0]  lo_rdata_q;
  logic                   is_idle, take_request;

  phase_e                 cur_phase, lo_start, hi_start, seq_next;
  logic                   seq_done, tgt_half;
  logic [1:0]             tgt_mask;
  logic [HALF_WIDTH-1:0]  tgt_wdata, seq_rdata, merged_wdata;

  logic                       enable_d, sram_rw_d, ready_d;
  logic [SRAM_ADDR_WIDTH-1:0] address_d;
  logic [HALF_WIDTH-1:0]      sram_wdata_d;
  logic [31:0]                rdata_d;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_address[31:SRAM_ADDR_WIDTH+1], i_address[1:0]};

  // In IDLE the request fields come straight from the bus so the first access starts without delay.
  always_comb begin
    is_idle      = (state_q == ST_IDLE);
    take_request = is_idle && i_request && !o_ready;
    eff_word     = is_idle ? i_address[SRAM_ADDR_WIDTH:2] : word_q;
    eff_wdata    = is_idle ? i_wdata : wdata_q;
    eff_mask     = is_idle ? i_wmask : mask_q;
    eff_rw       = is_idle ? i_rw    : rw_q;
    lo_start     = start_phase(eff_mask[1:0], eff_rw);
    hi_start     = start_phase(eff_mask[3:2], eff_rw);
    cur_phase    = state_phase(state_q);
    tgt_half     = state_half(state_d);
    tgt_mask     = (tgt_half == HI) ? eff_mask[3:2]   : eff_mask[1:0];
    tgt_wdata    = (tgt_half == HI) ? eff_wdata[31:16] : eff_wdata[15:0];
  end

  sram_bridge32_half_sequencer u_half_seq (
    .i_clock          (i_clock),
    .i_reset_n        (i_reset_n),
    .i_phase          (cur_phase),
    .i_rw             (eff_rw),
    .i_half_mask      (tgt_mask),
    .i_wdata          (tgt_wdata),
    .i_sram_ready     (i_sram_ready),
    .i_sram_rdata     (i_sram_rdata),
    .o_next_phase_c   (seq_next),
    .o_done_c         (seq_done),
    .o_rdata          (seq_rdata),
    .o_merged_wdata_c (merged_wdata)
  );

  // State register.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  // Next state: sequence LO then HI, skipping empty halves; never start while ready is still high.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (take_request && !i_sram_ready) begin
          if (lo_start != PH_NONE)      state_d = half_state(LO, lo_start);
          else if (hi_start != PH_NONE) state_d = half_state(HI, hi_start);
          else                          state_d = ST_DONE;
        end
      end
      ST_LO_RD, ST_LO_WR, ST_LO_REL: begin
        if (seq_done) state_d = (hi_start != PH_NONE) ? half_state(HI, hi_start) : ST_DONE;
        else          state_d = half_state(LO, seq_next);
      end
      ST_HI_RD, ST_HI_WR, ST_HI_REL: begin
        if (seq_done) state_d = ST_DONE;
        else          state_d = half_state(HI, seq_next);
      end
      ST_DONE: begin
        if (!i_request) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output values for the upcoming state, registered below.
  always_comb begin
    enable_d     = (state_phase(state_d) == PH_RD) || (state_phase(state_d) == PH_WR);
    sram_rw_d    = (state_phase(state_d) == PH_WR);
    address_d    = enable_d ? {eff_word, tgt_half} : '0;
    sram_wdata_d = sram_rw_d ? merged_wdata : '0;
    ready_d      = (state_d == ST_DONE);
    rdata_d      = o_rdata;
    if (state_d == ST_DONE && state_q != ST_DONE && !eff_rw) begin
      rdata_d = {seq_rdata, lo_rdata_q};
    end
  end

  // Latch the request and keep the low half of a read once that half completes.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      word_q     <= '0;
      wdata_q    <= '0;
      mask_q     <= '0;
      rw_q       <= 1'b0;
      lo_rdata_q <= '0;
    end else begin
      if (take_request) begin
        word_q  <= i_address[SRAM_ADDR_WIDTH:2];
        wdata_q <= i_wdata;
        mask_q  <= i_wmask;
        rw_q    <= i_rw;
      end
      if (state_half(state_q) == LO && cur_phase == PH_REL && seq_done) begin
        lo_rdata_q <= seq_rdata;
      end
    end
  end

  // Output registers; reset clears them immediately, abandoning any SRAM access.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_sram_enable  <= 1'b0;
      o_sram_rw      <= 1'b0;
      o_sram_address <= '0;
      o_sram_wdata   <= '0;
      o_ready        <= 1'b0;
      o_rdata        <= '0;
    end else begin
      o_sram_enable  <= enable_d;
      o_sram_rw      <= sram_rw_d;
      o_sram_address <= address_d;
      o_sram_wdata   <= sram_wdata_d;
      o_ready        <= ready_d;
      o_rdata        <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sram_bridge32.sv
// Self-checking bench for sram_bridge32 with a one-cycle SRAM responder and a word-level reference model.
module tb_sram_bridge32;

  typedef struct packed {
    logic        rw;
    logic [17:0] addr;
    logic [15:0] data;
  } acc_t;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        request;
  logic        rw;
  logic [31:0] address;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] rdata;
  logic        ready;
  logic        sram_enable;
  logic        sram_rw;
  logic [17:0] sram_address;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = '0;
  logic        sram_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] sram_mem [0:1023];
  logic [15:0] ref_mem  [0:1023];
  bit          mem_loaded = 1'b0;
  acc_t        sram_log [$];
  acc_t        exp_q    [$];
  int          viol   = 0;
  int          en_cnt = 0;
  logic        prev_en = 1'b0;
  logic        prev_rw = 1'b0;
  logic [17:0] prev_addr = '0;
  logic [31:0] last_rdata;
  logic [31:0] exp_rd;

  always #5 clock = ~clock;

  sram_bridge32 dut (
    .i_clock        (clock),
    .i_reset_n      (reset_n),
    .i_request      (request),
    .i_rw           (rw),
    .i_address      (address),
    .i_wdata        (wdata),
    .i_wmask        (wmask),
    .o_rdata        (rdata),
    .o_ready        (ready),
    .o_sram_enable  (sram_enable),
    .o_sram_rw      (sram_rw),
    .o_sram_address (sram_address),
    .o_sram_wdata   (sram_wdata),
    .i_sram_rdata   (sram_rdata),
    .i_sram_ready   (sram_ready)
  );

  function automatic logic [15:0] preload(input int i);
    if (i == 256) return 16'hBEEF;
    if (i == 257) return 16'hDEAD;
    return 16'(i * 40503 + 12345);
  endfunction

  // SRAM responder: ready follows enable by one edge; also watches handshake rules.
  always @(posedge clock) begin
    acc_t a;
    if (!mem_loaded) begin
      for (int i = 0; i < 1024; i++) sram_mem[i] = preload(i);
      mem_loaded = 1'b1;
    end
    if (sram_enable && !sram_ready) begin
      a.rw   = sram_rw;
      a.addr = sram_address;
      if (sram_rw) begin
        a.data = sram_wdata;
        sram_mem[sram_address[9:0]] = sram_wdata;
      end else begin
        a.data = sram_mem[sram_address[9:0]];
        sram_rdata <= a.data;
      end
      sram_log.push_back(a);
    end
    sram_ready <= sram_enable;
    if (sram_enable) en_cnt++;
    if (sram_enable && !prev_en && sram_ready) viol++;
    if (sram_enable && prev_en && (sram_address != prev_addr || sram_rw != prev_rw)) viol++;
    if (!(sram_enable && sram_rw) && sram_wdata != 16'h0) viol++;
    prev_en   = sram_enable;
    prev_rw   = sram_rw;
    prev_addr = sram_address;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Word-level model: which half-word accesses must happen, resulting memory and read data.
  task automatic model_txn(input logic m_rw, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] m);
    int unsigned w;
    logic [17:0] ha;
    logic [1:0]  hm;
    logic [15:0] old, nw;
    acc_t        a;
    exp_q.delete();
    exp_rd = last_rdata;
    w = (addr / 4) % 131072;
    for (int h = 0; h < 2; h++) begin
      ha  = 18'(w * 2 + h);
      old = ref_mem[ha[9:0]];
      if (!m_rw) begin
        a = '{rw: 1'b0, addr: ha, data: old};
        exp_q.push_back(a);
        exp_rd[16*h +: 16] = old;
      end else begin
        hm = 2'((m >> (2 * h)) & 4'd3);
        nw = old;
        if (hm != 2'b11 && hm != 2'b00) begin
          a = '{rw: 1'b0, addr: ha, data: old};
          exp_q.push_back(a);
        end
        for (int b = 0; b < 2; b++) if (hm[b]) nw[8*b +: 8] = wd[16*h + 8*b +: 8];
        if (hm != 2'b00) begin
          a = '{rw: 1'b1, addr: ha, data: nw};
          exp_q.push_back(a);
          ref_mem[ha[9:0]] = nw;
        end
      end
    end
  endtask

  // One CPU access; called and returns at 1 time unit after a rising edge.
  task automatic run_txn(input string name, input logic t_rw, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] m);
    int lat, start_idx, viol0, en0, n_got, n_min, n_exp;
    model_txn(t_rw, addr, wd, m);
    n_exp     = exp_q.size();
    start_idx = sram_log.size();
    viol0     = viol;
    en0       = en_cnt;
    request = 1'b1; rw = t_rw; address = addr; wdata = wd; wmask = m;
    lat = 0;
    while (!ready && lat < 200) begin
      @(posedge clock); #1;
      lat++;
    end
    check({name, ":ready"}, 32'(ready), 32'd1);
    check({name, ":latency"}, 32'(lat), (n_exp == 0) ? 32'd1 : 32'(1 + 4 * n_exp));
    check({name, ":rdata"}, rdata, exp_rd);
    @(posedge clock); #1;
    check({name, ":ready_hold"}, 32'(ready), 32'd1);
    check({name, ":rdata_hold"}, rdata, exp_rd);
    request = 1'b0;
    @(posedge clock); #1;
    check({name, ":ready_clr"}, 32'(ready), 32'd0);
    n_got = sram_log.size() - start_idx;
    check({name, ":n_access"}, 32'(n_got), 32'(n_exp));
    n_min = (n_got < n_exp) ? n_got : n_exp;
    for (int i = 0; i < n_min; i++) begin
      check({name, ":acc_rw_addr"}, {sram_log[start_idx+i].rw, 13'd0, sram_log[start_idx+i].addr},
            {exp_q[i].rw, 13'd0, exp_q[i].addr});
      check({name, ":acc_data"}, 32'(sram_log[start_idx+i].data), 32'(exp_q[i].data));
    end
    for (int i = 0; i < n_exp; i++) begin
      check({name, ":mem"}, 32'(sram_mem[exp_q[i].addr[9:0]]), 32'(ref_mem[exp_q[i].addr[9:0]]));
    end
    check({name, ":enable_cycles"}, 32'(en_cnt - en0), 32'(2 * n_exp));
    check({name, ":handshake"}, 32'(viol - viol0), 32'd0);
    last_rdata = exp_rd;
  endtask

  initial begin
    int guard;
    for (int i = 0; i < 1024; i++) ref_mem[i] = preload(i);
    reset_n = 1'b0; request = 1'b0; rw = 1'b0; address = '0; wdata = '0; wmask = '0;
    last_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst:ready", 32'(ready), 32'd0);
    check("rst:rdata", rdata, 32'd0);
    check("rst:enable", 32'(sram_enable), 32'd0);
    check("rst:sram_rw", 32'(sram_rw), 32'd0);
    check("rst:addr", 32'(sram_address), 32'd0);
    check("rst:wdata", 32'(sram_wdata), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    run_txn("read",    1'b0, 32'h0000_0200, 32'h0,         4'b0000);
    check("read:word", last_rdata, 32'hDEAD_BEEF);
    run_txn("wr_full", 1'b1, 32'h0000_0204, 32'h1234_5678, 4'b1111);
    check("wr_full:lo", 32'(sram_mem[10'h102]), 32'h5678);
    check("wr_full:hi", 32'(sram_mem[10'h103]), 32'h1234);
    run_txn("rmw",     1'b1, 32'h0000_0200, 32'h0000_AB00, 4'b0010);
    check("rmw:lo", 32'(sram_mem[10'h100]), 32'hABEF);
    run_txn("mask0",   1'b1, 32'h0000_0200, 32'hCAFE_F00D, 4'b0000);
    run_txn("b2b_a",   1'b0, 32'h0000_0204, 32'h0,         4'b0000);
    run_txn("b2b_b",   1'b0, 32'h0000_0200, 32'h0,         4'b0000);
    check("b2b_b:word", last_rdata, 32'hDEAD_ABEF);

    // Reset while the low-half write strobe is up.
    request = 1'b1; rw = 1'b1; address = 32'h0000_0204; wdata = 32'hA5A5_5A5A; wmask = 4'b1111;
    guard = 0;
    while (!(sram_enable && sram_rw) && guard < 20) begin
      @(posedge clock); #1;
      guard++;
    end
    check("midrst:lo_wr", {31'd0, sram_enable && sram_rw}, 32'd1);
    check("midrst:lo_addr", 32'(sram_address), 32'h102);
    #2 reset_n = 1'b0;
    #1;
    check("midrst:enable", 32'(sram_enable), 32'd0);
    check("midrst:sram_rw", 32'(sram_rw), 32'd0);
    check("midrst:addr", 32'(sram_address), 32'd0);
    check("midrst:wdata", 32'(sram_wdata), 32'd0);
    check("midrst:ready", 32'(ready), 32'd0);
    check("midrst:rdata", rdata, 32'd0);
    request = 1'b0;
    last_rdata = '0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    @(posedge clock); #1;
    run_txn("post_rst", 1'b0, 32'h0000_0200, 32'h0, 4'b0000);

    // Randomized accesses, including wrapped upper address bits and ignored byte offsets.
    for (int k = 0; k < 40; k++) begin
      logic [31:0] a;
      a = ($urandom() & 32'hFFF8_0000) | (32'($urandom_range(0, 511)) << 2) | 32'($urandom_range(0, 3));
      run_txn($sformatf("rand%0d", k), 1'($urandom_range(0, 1)), a, $urandom(), 4'($urandom_range(0, 15)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
